// File: rtl/debounce_multi.sv
// Multi-channel input debouncer: per-channel 2-FF synchroniser and stability counter,
// one shared prescaler tick, runtime threshold. Optional glitch counters: DEBOUNCE_GLITCH_CNT_EN.

module debounce_lane #(
    parameter int   COUNTER_SZ  = 8,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in,
    input  logic                  i_tick,
    input  logic [COUNTER_SZ-1:0] i_thr_eff,
    input  logic                  i_glitch_clr,
    output logic                  o_out,
    output logic                  o_up,
    output logic                  o_down,
    output logic                  o_accept,
    output logic [7:0]            o_glitch
);

    logic                  r_sync0, r_sync1;
    logic                  r_out, r_up, r_down, r_pend;
    logic [COUNTER_SZ-1:0] r_cnt;
    logic                  w_mis, w_acc;
    logic [COUNTER_SZ:0]   w_cnt_inc;

    assign w_mis     = (r_sync1 != r_out);
    assign w_cnt_inc = {1'b0, r_cnt} + (COUNTER_SZ+1)'(1);
    // Extra MSB keeps cnt+1 from wrapping before the compare.
    assign w_acc     = w_mis && i_tick && (w_cnt_inc >= {1'b0, i_thr_eff});

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync0 <= RESET_LEVEL;
            r_sync1 <= RESET_LEVEL;
            r_out   <= RESET_LEVEL;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_in;
            r_sync1 <= r_sync0;
            r_up    <= w_acc && r_sync1;
            r_down  <= w_acc && !r_sync1;
            if (!w_mis) begin
                r_cnt  <= '0;
                r_pend <= 1'b0;
            end else if (w_acc) begin
                r_out  <= r_sync1;
                r_cnt  <= '0;
                r_pend <= 1'b0;
            end else if (i_tick) begin
                if (r_cnt != '1)
                    r_cnt <= w_cnt_inc[COUNTER_SZ-1:0];
                r_pend <= 1'b1;
            end else begin
                r_pend <= 1'b1;
            end
        end
    end

    assign o_out    = r_out;
    assign o_up     = r_up;
    assign o_down   = r_down;
    assign o_accept = w_acc;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] r_glitch;
    logic       w_glitch;

    // A pending mismatch that vanished without acceptance was a rejected glitch.
    assign w_glitch = r_pend && !w_mis;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_glitch <= '0;
        else if (i_glitch_clr)
            r_glitch <= '0;
        else if (w_glitch && (r_glitch != 8'hFF))
            r_glitch <= r_glitch + 8'd1;
    end

    assign o_glitch = r_glitch;
`else
    logic w_unused;
    assign w_unused = ^{i_glitch_clr, r_pend};
    assign o_glitch = '0;
`endif

endmodule

module debounce_multi #(
    parameter int   CHANNELS    = 4,
    parameter int   COUNTER_SZ  = 8,
    parameter int   PRESCALE    = 54,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [CHANNELS-1:0]   i_signal_in,
    input  logic [COUNTER_SZ-1:0] i_threshold,
    input  logic                  i_glitch_clr,
    output logic [CHANNELS-1:0]   o_signal_out,
    output logic [CHANNELS-1:0]   o_signal_up,
    output logic [CHANNELS-1:0]   o_signal_down,
    output logic [CHANNELS-1:0]   o_signal_change,
    output logic                  o_any_change,
    output logic [CHANNELS*8-1:0] o_glitch_cnt
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]              r_pcnt;
    logic                       w_tick;
    logic [COUNTER_SZ-1:0]      w_thr_eff;
    logic [CHANNELS-1:0]        w_acc;
    logic [CHANNELS-1:0][7:0]   w_glitch;
    logic                       r_any;

    // Free-running time base; with PRESCALE=1 the counter sits at 0 and tick stays high.
    assign w_tick = (r_pcnt == PMAX);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_pcnt <= '0;
        else if (w_tick)
            r_pcnt <= '0;
        else
            r_pcnt <= r_pcnt + PW'(1);
    end

    assign w_thr_eff = (i_threshold == '0) ? COUNTER_SZ'(1) : i_threshold;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        debounce_lane #(
            .COUNTER_SZ  (COUNTER_SZ),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_lane (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_in         (i_signal_in[g]),
            .i_tick       (w_tick),
            .i_thr_eff    (w_thr_eff),
            .i_glitch_clr (i_glitch_clr),
            .o_out        (o_signal_out[g]),
            .o_up         (o_signal_up[g]),
            .o_down       (o_signal_down[g]),
            .o_accept     (w_acc[g]),
            .o_glitch     (w_glitch[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_any <= 1'b0;
        else
            r_any <= |w_acc;
    end

    assign o_signal_change = o_signal_up | o_signal_down;
    assign o_any_change    = r_any;
    assign o_glitch_cnt    = w_glitch;

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised and directed bench for debounce_multi: three configurations checked every
// cycle against a rule-level reference model, plus latency/boundary checks with fixed numbers.

module tb_debounce_multi;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam bit GEN = 1'b1;
`else
    localparam bit GEN = 1'b0;
`endif

    localparam int ND = 3;
    localparam int PS  [ND] = '{1, 54, 1};
    localparam int CS  [ND] = '{8, 8, 4};
    localparam int NC  [ND] = '{4, 4, 2};
    localparam bit RLV [ND] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, gclr;
    logic [3:0] a_in, b_in;
    logic [1:0] c_in;
    logic [7:0] a_thr, b_thr;
    logic [3:0] c_thr;
    logic [3:0] a_out, a_up, a_dn, a_chg, b_out, b_up, b_dn, b_chg;
    logic [1:0] c_out, c_up, c_dn, c_chg;
    logic a_any, b_any, c_any;
    logic [31:0] a_gl, b_gl;
    logic [15:0] c_gl;

    debounce_multi #(.CHANNELS(4), .COUNTER_SZ(8), .PRESCALE(1), .RESET_LEVEL(1'b0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_signal_in(a_in), .i_threshold(a_thr),
        .i_glitch_clr(gclr), .o_signal_out(a_out), .o_signal_up(a_up), .o_signal_down(a_dn),
        .o_signal_change(a_chg), .o_any_change(a_any), .o_glitch_cnt(a_gl));

    debounce_multi #(.CHANNELS(4), .COUNTER_SZ(8), .PRESCALE(54), .RESET_LEVEL(1'b1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_signal_in(b_in), .i_threshold(b_thr),
        .i_glitch_clr(gclr), .o_signal_out(b_out), .o_signal_up(b_up), .o_signal_down(b_dn),
        .o_signal_change(b_chg), .o_any_change(b_any), .o_glitch_cnt(b_gl));

    debounce_multi #(.CHANNELS(2), .COUNTER_SZ(4), .PRESCALE(1), .RESET_LEVEL(1'b0)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_signal_in(c_in), .i_threshold(c_thr),
        .i_glitch_clr(gclr), .o_signal_out(c_out), .o_signal_up(c_up), .o_signal_down(c_dn),
        .o_signal_change(c_chg), .o_any_change(c_any), .o_glitch_cnt(c_gl));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the level seen by the filter is the input from two edges earlier;
    // a mismatch must survive thr_eff ticks (tick = every PS-th cycle since reset).
    logic [3:0] m_out [ND];
    logic [3:0] m_up  [ND];
    logic [3:0] m_dn  [ND];
    logic [3:0] m_d1  [ND];
    logic [3:0] m_d2  [ND];
    int         m_cnt [ND][4];
    bit         m_pend[ND][4];
    int         m_gl  [ND][4];
    int         m_cyc [ND];

    task automatic model_step(input int d, input logic [3:0] in, input int thr);
        bit   tick;
        int   te, cmax;
        logic s;
        if (!rst_n) begin
            m_out[d] = {4{RLV[d]}};
            m_d1[d]  = {4{RLV[d]}};
            m_d2[d]  = {4{RLV[d]}};
            m_up[d]  = '0;
            m_dn[d]  = '0;
            m_cyc[d] = 0;
            for (int ch = 0; ch < 4; ch++) begin
                m_cnt[d][ch] = 0; m_pend[d][ch] = 0; m_gl[d][ch] = 0;
            end
        end else begin
            tick = ((m_cyc[d] % PS[d]) == PS[d] - 1);
            m_cyc[d]++;
            te   = (thr == 0) ? 1 : thr;
            cmax = (1 << CS[d]) - 1;
            m_up[d] = '0;
            m_dn[d] = '0;
            for (int ch = 0; ch < NC[d]; ch++) begin
                s = m_d2[d][ch];
                if (s == m_out[d][ch]) begin
                    if (GEN && m_pend[d][ch] && m_gl[d][ch] < 255) m_gl[d][ch]++;
                    m_cnt[d][ch] = 0; m_pend[d][ch] = 0;
                end else if (!tick) begin
                    m_pend[d][ch] = 1;
                end else if (m_cnt[d][ch] + 1 >= te) begin
                    m_out[d][ch] = s;
                    if (s) m_up[d][ch] = 1'b1; else m_dn[d][ch] = 1'b1;
                    m_cnt[d][ch] = 0; m_pend[d][ch] = 0;
                end else begin
                    m_cnt[d][ch] = (m_cnt[d][ch] + 1 > cmax) ? cmax : m_cnt[d][ch] + 1;
                    m_pend[d][ch] = 1;
                end
                if (gclr) m_gl[d][ch] = 0;
            end
            m_d2[d] = m_d1[d];
            m_d1[d] = in;
        end
    endtask

    function automatic logic [31:0] gexp(input int d);
        logic [31:0] v = '0;
        for (int ch = 0; ch < NC[d]; ch++) v[8*ch +: 8] = m_gl[d][ch][7:0];
        return v;
    endfunction

    task automatic compare_all();
        chk("a_out", {28'b0, a_out}, {28'b0, m_out[0]});
        chk("a_up",  {28'b0, a_up},  {28'b0, m_up[0]});
        chk("a_dn",  {28'b0, a_dn},  {28'b0, m_dn[0]});
        chk("a_chg", {28'b0, a_chg}, {28'b0, m_up[0] | m_dn[0]});
        chk("a_any", {31'b0, a_any}, {31'b0, |(m_up[0] | m_dn[0])});
        chk("a_gl",  a_gl, gexp(0));
        chk("b_out", {28'b0, b_out}, {28'b0, m_out[1]});
        chk("b_up",  {28'b0, b_up},  {28'b0, m_up[1]});
        chk("b_dn",  {28'b0, b_dn},  {28'b0, m_dn[1]});
        chk("b_chg", {28'b0, b_chg}, {28'b0, m_up[1] | m_dn[1]});
        chk("b_any", {31'b0, b_any}, {31'b0, |(m_up[1] | m_dn[1])});
        chk("b_gl",  b_gl, gexp(1));
        chk("c_out", {30'b0, c_out}, {30'b0, m_out[2][1:0]});
        chk("c_up",  {30'b0, c_up},  {30'b0, m_up[2][1:0]});
        chk("c_dn",  {30'b0, c_dn},  {30'b0, m_dn[2][1:0]});
        chk("c_chg", {30'b0, c_chg}, {30'b0, m_up[2][1:0] | m_dn[2][1:0]});
        chk("c_any", {31'b0, c_any}, {31'b0, |(m_up[2][1:0] | m_dn[2][1:0])});
        chk("c_gl",  {16'b0, c_gl}, gexp(2));
    endtask

    // One clock: model advances on the edge, DUT compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step(0, a_in, int'(a_thr));
        model_step(1, b_in, int'(b_thr));
        model_step(2, {2'b0, c_in}, int'(c_thr));
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_evt(input int d, input int ch, input bit rise, input int maxc, output int n);
        logic p;
        n = 0;
        p = 1'b0;
        while (!p && n < maxc) begin
            step();
            n++;
            case (d)
                0:       p = rise ? a_up[ch] : a_dn[ch];
                1:       p = rise ? b_up[ch] : b_dn[ch];
                default: p = rise ? c_up[ch[0]] : c_dn[ch[0]];
            endcase
        end
        if (!p) n = -1;
    endtask

    int n;

    initial begin
        rst_n = 1'b0; gclr = 1'b0;
        a_in = '0; b_in = '1; c_in = '0;
        a_thr = 8'd1; b_thr = 8'd1; c_thr = 4'd1;

        // reset with toggling inputs
        repeat (3) begin
            b_in = 4'($urandom); a_in = 4'($urandom);
            step();
        end
        chk("rst_b_out", {28'b0, b_out}, 32'hF);
        chk("rst_b_evt", {24'b0, b_up, b_dn}, 32'h0);
        chk("rst_b_gl",  b_gl, 32'h0);
        chk("rst_a_out", {28'b0, a_out}, 32'h0);
        rst_n = 1'b1; b_in = '1; a_in = '0;
        repeat (10) step();
        chk("rel_b_out", {28'b0, b_out}, 32'hF);

        // acceptance latency, threshold 4
        a_thr = 8'd4; a_in[0] = 1'b1;
        wait_evt(0, 0, 1'b1, 20, n);
        chk("lat_thr4", n, 32'd6);
        chk("lat_chg", {28'b0, a_chg}, 32'h1);
        step();
        chk("lat_width", {28'b0, a_up}, 32'h0);
        chk("lat_out", {28'b0, a_out}, 32'h1);

        // threshold 0 behaves as 1
        a_thr = 8'd0; a_in[0] = 1'b0;
        wait_evt(0, 0, 1'b0, 20, n);
        chk("lat_thr0", n, 32'd3);

        // glitch rejection
        a_thr = 8'd8; a_in[1] = 1'b1;
        repeat (5) step();
        a_in[1] = 1'b0;
        repeat (20) step();
        chk("gl_out", {31'b0, a_out[1]}, 32'h0);
        chk("gl_one", {24'b0, a_gl[15:8]}, GEN ? 32'd1 : 32'd0);
        repeat (300) begin
            a_in[1] = 1'b1; step(); step();
            a_in[1] = 1'b0; step(); step();
        end
        repeat (5) step();
        chk("gl_sat", {24'b0, a_gl[15:8]}, GEN ? 32'd255 : 32'd0);

        // clear coinciding with a glitch increment
        gclr = 1'b1; step(); gclr = 1'b0;
        chk("gl_clr", {24'b0, a_gl[15:8]}, 32'd0);
        a_in[1] = 1'b1; repeat (3) step();
        a_in[1] = 1'b0; step(); step();
        gclr = 1'b1; step(); gclr = 1'b0;
        chk("gl_clr_coinc", {24'b0, a_gl[15:8]}, 32'd0);
        a_in[1] = 1'b1; repeat (3) step();
        a_in[1] = 1'b0; repeat (10) step();
        chk("gl_after_clr", {24'b0, a_gl[15:8]}, GEN ? 32'd1 : 32'd0);

        // simultaneous acceptance
        a_thr = 8'd3; a_in[0] = 1'b1; a_in[3] = 1'b1;
        wait_evt(0, 0, 1'b1, 20, n);
        chk("sim_lat", n, 32'd5);
        chk("sim_up", {28'b0, a_up}, 32'h9);
        chk("sim_any", {31'b0, a_any}, 32'h1);

        // live threshold drop while cnt=50
        a_thr = 8'd200; a_in[2] = 1'b1;
        repeat (52) step();
        chk("live_pre", {31'b0, a_out[2]}, 32'h0);
        a_thr = 8'd10;
        wait_evt(0, 2, 1'b1, 5, n);
        chk("live_next", n, 32'd1);

        // no-wrap counter, 4-bit, threshold 15
        c_thr = 4'd15; c_in[0] = 1'b1;
        wait_evt(2, 0, 1'b1, 40, n);
        chk("sat_lat", n, 32'd17);

        // prescaled timing and prescaled glitch
        b_thr = 8'd50; b_in[2] = 1'b0;
        wait_evt(1, 2, 1'b0, 3000, n);
        chk("ps_lat_rng", {31'b0, (n >= 2649 && n <= 2702)}, 32'h1);
        b_in[2] = 1'b1;
        repeat (40 * 54) step();
        b_in[2] = 1'b0;
        repeat (200) step();
        chk("ps_gl_out", {31'b0, b_out[2]}, 32'h0);
        chk("ps_gl_cnt", {24'b0, b_gl[23:16]}, GEN ? 32'd1 : 32'd0);

        // randomised traffic with occasional clear and mid-count reset
        for (int i = 0; i < 6000; i++) begin
            if (i % 64 == 0) begin
                a_thr = 8'($urandom_range(0, 6));
                c_thr = 4'($urandom_range(0, 15));
                b_thr = 8'($urandom_range(0, 2));
            end
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 7) == 0) a_in[ch] = ~a_in[ch];
                if ($urandom_range(0, 299) == 0) b_in[ch] = ~b_in[ch];
            end
            for (int ch = 0; ch < 2; ch++)
                if ($urandom_range(0, 9) == 0) c_in[ch] = ~c_in[ch];
            gclr  = ($urandom_range(0, 199) == 0);
            rst_n = ($urandom_range(0, 799) != 0);
            step();
        end
        rst_n = 1'b1; gclr = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
